// File: rtl/forwarding_unit_alu_operands_if.sv
// rtl/forwarding_unit_alu_operands_if.sv - pipeline-side bundle for the EX-stage forwarding unit (FWD_STATS_EN adds counters)
interface forwarding_unit_alu_operands_if #(
   parameter int DATA_W  = 64,
   parameter int REG_AW  = 5,
   parameter int NUM_OPS = 2
);
   logic                        idValid;
   logic [NUM_OPS*REG_AW-1:0]   idSrcReg;
   logic [NUM_OPS-1:0]          idSrcUsed;
   logic                        idexMemRead;
   logic [REG_AW-1:0]           idexRd;
   logic [NUM_OPS*REG_AW-1:0]   exSrcReg;
   logic [NUM_OPS*DATA_W-1:0]   exRegData;
   logic                        exmemRegWrite;
   logic [REG_AW-1:0]           exmemRd;
   logic [DATA_W-1:0]           exmemResult;
   logic                        memwbRegWrite;
   logic [REG_AW-1:0]           memwbRd;
   logic [DATA_W-1:0]           memwbResult;
   logic [NUM_OPS*DATA_W-1:0]   exOperand;
   logic [NUM_OPS*2-1:0]        forwardSel;
   logic                        stall;
   logic                        bubble;
`ifdef FWD_STATS_EN
   logic [31:0]                 fwdCntExmem;
   logic [31:0]                 fwdCntMemwb;
   logic [31:0]                 fwdCntHist;
   logic [31:0]                 stallCnt;
`endif

   modport master (
      output idValid, idSrcReg, idSrcUsed, idexMemRead, idexRd,
      output exSrcReg, exRegData, exmemRegWrite, exmemRd, exmemResult,
      output memwbRegWrite, memwbRd, memwbResult,
`ifdef FWD_STATS_EN
      input  fwdCntExmem, fwdCntMemwb, fwdCntHist, stallCnt,
`endif
      input  exOperand, forwardSel, stall, bubble
   );

   modport slave (
      input  idValid, idSrcReg, idSrcUsed, idexMemRead, idexRd,
      input  exSrcReg, exRegData, exmemRegWrite, exmemRd, exmemResult,
      input  memwbRegWrite, memwbRd, memwbResult,
`ifdef FWD_STATS_EN
      output fwdCntExmem, fwdCntMemwb, fwdCntHist, stallCnt,
`endif
      output exOperand, forwardSel, stall, bubble
   );
endinterface

// File: rtl/forwarding_unit_alu_operands.sv
// rtl/forwarding_unit_alu_operands.sv - LEGv8 EX-stage operand forwarding with writeback history and load-use stall
// Optional usage counters are compiled in with FWD_STATS_EN.
module forwarding_unit_alu_operands #(
   parameter int DATA_W     = 64,
   parameter int REG_AW     = 5,
   parameter int NUM_OPS    = 2,
   parameter int HIST_DEPTH = 2,
   parameter int LOAD_STALL = 1,
   parameter int ZERO_REG   = 31
) (
   input  logic clk,
   input  logic rst_n,
   forwarding_unit_alu_operands_if.slave bus
);

   localparam logic [REG_AW-1:0] ZR        = REG_AW'(ZERO_REG);
   localparam logic [3:0]        HOLD_INIT = 4'(LOAD_STALL - 2);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } hist_t;

   hist_t hist [HIST_DEPTH];

   // History keeps shifting through stalls so retired values age out on schedule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
      end else begin
         hist[0].valid <= bus.memwbRegWrite && (bus.memwbRd != ZR);
         hist[0].rd    <= bus.memwbRd;
         hist[0].data  <= bus.memwbResult;
         for (int k = 1; k < HIST_DEPTH; k++) hist[k] <= hist[k-1];
      end
   end

   logic [NUM_OPS-1:0] useExmem;
   logic [NUM_OPS-1:0] useMemwb;
   logic [NUM_OPS-1:0] useHist;
   logic [NUM_OPS-1:0] idMatch;

   for (genvar i = 0; i < NUM_OPS; i++) begin : gOp
      logic [REG_AW-1:0] src;
      logic [DATA_W-1:0] regData;
      logic              histHit;
      logic [DATA_W-1:0] histData;
      logic [1:0]        sel;
      logic [DATA_W-1:0] opData;

      assign src     = bus.exSrcReg[i*REG_AW +: REG_AW];
      assign regData = bus.exRegData[i*DATA_W +: DATA_W];

      // Scan oldest to newest so the newest matching entry is the one kept.
      always_comb begin
         histHit  = 1'b0;
         histData = '0;
         for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (hist[k].valid && (hist[k].rd == src)) begin
               histHit  = 1'b1;
               histData = hist[k].data;
            end
         end
      end

      always_comb begin
         sel    = 2'b00;
         opData = regData;
         if (src == ZR) begin
            sel    = 2'b00;
            opData = regData;
         end else if (bus.exmemRegWrite && (bus.exmemRd == src)) begin
            sel    = 2'b10;
            opData = bus.exmemResult;
         end else if (bus.memwbRegWrite && (bus.memwbRd == src)) begin
            sel    = 2'b01;
            opData = bus.memwbResult;
         end else if (histHit) begin
            sel    = 2'b11;
            opData = histData;
         end
      end

      assign bus.exOperand[i*DATA_W +: DATA_W] = opData;
      assign bus.forwardSel[i*2 +: 2]          = sel;
      assign useExmem[i] = (sel == 2'b10);
      assign useMemwb[i] = (sel == 2'b01);
      assign useHist[i]  = (sel == 2'b11);
      assign idMatch[i]  = bus.idSrcUsed[i] && (bus.idSrcReg[i*REG_AW +: REG_AW] == bus.idexRd);
   end

   logic hz;
   assign hz = bus.idValid && bus.idexMemRead && (bus.idexRd != ZR) && (|idMatch);

   typedef enum logic {RUN, HOLD} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic       stallInt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         case (state)
            RUN: begin
               if (hz && (LOAD_STALL > 1)) begin
                  state <= HOLD;
                  cnt   <= HOLD_INIT;
               end
            end
            HOLD: begin
               if (cnt == 4'd0) state <= RUN;
               else             cnt   <= cnt - 4'd1;
            end
            default: state <= RUN;
         endcase
      end
   end

   // The first stall cycle comes straight from the hazard; gating with rst_n drops it during reset.
   assign stallInt   = rst_n && ((state == HOLD) || hz);
   assign bus.stall  = stallInt;
   assign bus.bubble = stallInt;

`ifdef FWD_STATS_EN
   logic [31:0] cntExmem;
   logic [31:0] cntMemwb;
   logic [31:0] cntHist;
   logic [31:0] cntStall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntExmem <= '0;
         cntMemwb <= '0;
         cntHist  <= '0;
         cntStall <= '0;
      end else begin
         if ((|useExmem) && (cntExmem != 32'hFFFF_FFFF)) cntExmem <= cntExmem + 32'd1;
         if ((|useMemwb) && (cntMemwb != 32'hFFFF_FFFF)) cntMemwb <= cntMemwb + 32'd1;
         if ((|useHist)  && (cntHist  != 32'hFFFF_FFFF)) cntHist  <= cntHist  + 32'd1;
         if (stallInt    && (cntStall != 32'hFFFF_FFFF)) cntStall <= cntStall + 32'd1;
      end
   end

   assign bus.fwdCntExmem = cntExmem;
   assign bus.fwdCntMemwb = cntMemwb;
   assign bus.fwdCntHist  = cntHist;
   assign bus.stallCnt    = cntStall;
`endif

endmodule

// File: tb/tb_forwarding_unit_alu_operands.sv
// tb/tb_forwarding_unit_alu_operands.sv - self-checking bench for forwarding_unit_alu_operands
module tb_forwarding_unit_alu_operands;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   localparam logic [63:0] REG0 = 64'h1000;
   localparam logic [63:0] REG1 = 64'h2000;
   localparam logic [63:0] EXR  = 64'hAA;
   localparam logic [63:0] MWR  = 64'hBB;

   forwarding_unit_alu_operands_if #(.DATA_W(64), .REG_AW(5), .NUM_OPS(2)) bus ();

   forwarding_unit_alu_operands #(
      .DATA_W(64), .REG_AW(5), .NUM_OPS(2), .HIST_DEPTH(2), .LOAD_STALL(3), .ZERO_REG(31)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  src0;
      logic [4:0]  src1;
      logic        exWr;
      logic [4:0]  exRd;
      logic        mwWr;
      logic [4:0]  mwRd;
      logic [1:0]  sel0;
      logic [1:0]  sel1;
      logic [63:0] op0;
      logic [63:0] op1;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOp0(input string name, input logic [1:0] sel, input logic [63:0] op);
      check({name, "_sel0"}, 64'(bus.forwardSel[1:0]), 64'(sel));
      check({name, "_op0"}, bus.exOperand[63:0], op);
   endtask

   task automatic checkStall(input string name, input logic exp);
      check({name, "_stall"}, 64'(bus.stall), 64'(exp));
      check({name, "_bubble"}, 64'(bus.bubble), 64'(exp));
   endtask

   task automatic clearId();
      bus.idValid     = 1'b0;
      bus.idSrcReg    = '0;
      bus.idSrcUsed   = '0;
      bus.idexMemRead = 1'b0;
      bus.idexRd      = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clearId();
      bus.exSrcReg      = '0;
      bus.exRegData     = {REG1, REG0};
      bus.exmemRegWrite = 1'b0;
      bus.exmemRd       = '0;
      bus.exmemResult   = EXR;
      bus.memwbRegWrite = 1'b0;
      bus.memwbRd       = '0;
      bus.memwbResult   = MWR;

      //            src0   src1   exWr  exRd   mwWr  mwRd   sel0   sel1   op0   op1
      vecs[0] = '{5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  2'b00, 2'b00, REG0, REG1};
      vecs[1] = '{5'd3,  5'd4,  1'b1, 5'd3,  1'b1, 5'd3,  2'b10, 2'b00, EXR,  REG1};
      vecs[2] = '{5'd3,  5'd31, 1'b1, 5'd31, 1'b0, 5'd0,  2'b00, 2'b00, REG0, REG1};
      vecs[3] = '{5'd3,  5'd4,  1'b0, 5'd0,  1'b1, 5'd4,  2'b00, 2'b01, REG0, MWR};
      vecs[4] = '{5'd6,  5'd6,  1'b1, 5'd6,  1'b0, 5'd0,  2'b10, 2'b10, EXR,  EXR};
      vecs[5] = '{5'd3,  5'd4,  1'b0, 5'd3,  1'b1, 5'd3,  2'b01, 2'b00, MWR,  REG1};
      vecs[6] = '{5'd3,  5'd4,  1'b1, 5'd3,  1'b1, 5'd4,  2'b10, 2'b01, EXR,  MWR};
      vecs[7] = '{5'd5,  5'd31, 1'b0, 5'd5,  1'b0, 5'd5,  2'b00, 2'b00, REG0, REG1};

      // Held in reset so the history stays empty while the priority table is swept.
      for (int v = 0; v < 8; v++) begin
         bus.exSrcReg      = {vecs[v].src1, vecs[v].src0};
         bus.exmemRegWrite = vecs[v].exWr;
         bus.exmemRd       = vecs[v].exRd;
         bus.memwbRegWrite = vecs[v].mwWr;
         bus.memwbRd       = vecs[v].mwRd;
         #1;
         check($sformatf("vec%0d_sel0", v), 64'(bus.forwardSel[1:0]), 64'(vecs[v].sel0));
         check($sformatf("vec%0d_sel1", v), 64'(bus.forwardSel[3:2]), 64'(vecs[v].sel1));
         check($sformatf("vec%0d_op0", v), bus.exOperand[63:0], vecs[v].op0);
         check($sformatf("vec%0d_op1", v), bus.exOperand[127:64], vecs[v].op1);
      end

      bus.idValid = 1'b1; bus.idexMemRead = 1'b1; bus.idexRd = 5'd7;
      bus.idSrcReg = {5'd0, 5'd7}; bus.idSrcUsed = 2'b01;
      #1 checkStall("in_reset", 1'b0);

      bus.exmemRegWrite = 1'b0;
      bus.memwbRegWrite = 1'b0;
      clearId();
      @(negedge clk);
      rst_n = 1'b1;

      // Retired write to X5 is served from history for two cycles, then ages out.
      bus.exSrcReg      = {5'd4, 5'd5};
      bus.memwbRegWrite = 1'b1; bus.memwbRd = 5'd5; bus.memwbResult = 64'h55;
      #1 checkOp0("hist_live", 2'b01, 64'h55);
      @(negedge clk);
      bus.memwbRegWrite = 1'b0; bus.memwbResult = MWR;
      #1 checkOp0("hist_age1", 2'b11, 64'h55);
      @(negedge clk);
      #1 checkOp0("hist_age2", 2'b11, 64'h55);
      @(negedge clk);
      #1 checkOp0("hist_gone", 2'b00, REG0);

      bus.exSrcReg      = {5'd4, 5'd9};
      bus.memwbRegWrite = 1'b1; bus.memwbRd = 5'd9; bus.memwbResult = 64'h91;
      @(negedge clk);
      bus.memwbResult = 64'h92;
      @(negedge clk);
      bus.memwbRegWrite = 1'b0; bus.memwbResult = MWR;
      #1 checkOp0("hist_dup_newest", 2'b11, 64'h92);
      bus.exmemRegWrite = 1'b1; bus.exmemRd = 5'd9;
      #1 checkOp0("exmem_over_hist", 2'b10, EXR);
      bus.exmemRegWrite = 1'b0;

      // Three-cycle load-use stall; hazard dropped after the first edge since HOLD ignores it.
      @(negedge clk);
      bus.idValid = 1'b1; bus.idexMemRead = 1'b1; bus.idexRd = 5'd7;
      bus.idSrcReg = {5'd0, 5'd7}; bus.idSrcUsed = 2'b01;
      #1 checkStall("ls_c1", 1'b1);
      @(posedge clk);
      #1 clearId();
      @(negedge clk);
      #1 checkStall("ls_c2", 1'b1);
      @(negedge clk);
      #1 checkStall("ls_c3", 1'b1);
      @(negedge clk);
      #1 checkStall("ls_done", 1'b0);

      bus.idValid = 1'b1; bus.idexMemRead = 1'b1; bus.idexRd = 5'd31;
      bus.idSrcReg = {5'd0, 5'd31}; bus.idSrcUsed = 2'b01;
      #1 checkStall("no_hz_xzr", 1'b0);
      bus.idexRd = 5'd7; bus.idSrcReg = {5'd0, 5'd7}; bus.idSrcUsed = 2'b00;
      #1 checkStall("no_hz_unused", 1'b0);
      bus.idSrcUsed = 2'b01; bus.idexMemRead = 1'b0;
      #1 checkStall("no_hz_noload", 1'b0);
      clearId();

      // Reset during HOLD must kill the stall at once and empty the history.
      @(negedge clk);
      bus.idValid = 1'b1; bus.idexMemRead = 1'b1; bus.idexRd = 5'd7;
      bus.idSrcReg = {5'd7, 5'd0}; bus.idSrcUsed = 2'b10;
      bus.memwbRegWrite = 1'b1; bus.memwbRd = 5'd12; bus.memwbResult = 64'hC;
      #1 checkStall("rst_c1_op1", 1'b1);
      @(posedge clk);
      #1 clearId();
      bus.memwbRegWrite = 1'b0; bus.memwbResult = MWR;
      bus.exSrcReg = {5'd4, 5'd12};
      @(negedge clk);
      #1 checkStall("rst_c2", 1'b1);
      checkOp0("rst_pre_hist", 2'b11, 64'hC);
      rst_n = 1'b0;
      #1 checkStall("rst_abort", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkOp0("rst_hist_empty", 2'b00, REG0);
      checkStall("rst_run1", 1'b0);
      @(negedge clk);
      #1 checkStall("rst_run2", 1'b0);

`ifdef FWD_STATS_EN
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      bus.exSrcReg = {5'd3, 5'd3};
      bus.exmemRegWrite = 1'b1; bus.exmemRd = 5'd3;
      repeat (10) @(negedge clk);
      bus.exmemRegWrite = 1'b0;
      #1 check("stats_exmem", 64'(bus.fwdCntExmem), 64'd10);
      check("stats_stall", 64'(bus.stallCnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
